// File: rtl/complex_mult.sv
// Pipelined fixed-point complex multiplier: dout = a * b on packed {im, re} operands,
// full-precision products, arithmetic right shift by SH, then per-component saturation.
module complex_mult #(
    parameter int OPERAND_WIDTH_A   = 16,
    parameter int OPERAND_WIDTH_B   = 16,
    parameter int OPERAND_WIDTH_OUT = 16,
    parameter int STAGES            = 6,
    parameter int BLOCKING          = 0,
    parameter int GROWTH_BITS       = 0
) (
    input  logic                           aclk,
    input  logic                           areset,
    input  logic [2*OPERAND_WIDTH_A-1:0]   s_axis_a_tdata,
    input  logic                           s_axis_a_tvalid,
    input  logic [2*OPERAND_WIDTH_B-1:0]   s_axis_b_tdata,
    input  logic                           s_axis_b_tvalid,
    output logic [2*OPERAND_WIDTH_OUT-1:0] m_axis_dout_tdata,
    output logic                           m_axis_dout_tvalid
);
    localparam int WA = OPERAND_WIDTH_A;
    localparam int WB = OPERAND_WIDTH_B;
    localparam int WO = OPERAND_WIDTH_OUT;
    localparam int MW = WA + WB;
    localparam int PW = WA + WB + 1;
    localparam int SH = WA + WB - WO + 1 + GROWTH_BITS;
    // Scaling width: wide enough for the sum and the saturation bounds, plus a sign bit.
    localparam int EW = ((PW > WO) ? PW : WO) + 1;

    localparam logic signed [EW-1:0] MAXV = {{(EW-WO+1){1'b0}}, {(WO-1){1'b1}}};
    localparam logic signed [EW-1:0] MINV = {{(EW-WO+1){1'b1}}, {(WO-1){1'b0}}};

    if (SH < 0) begin : g_bad_shift
        $error("complex_mult: negative output shift");
    end
    if (STAGES < 3) begin : g_bad_stages
        $error("complex_mult: STAGES must be at least 3");
    end

    logic accept;
    assign accept = s_axis_a_tvalid && (BLOCKING == 0 || s_axis_b_tvalid);

    logic [STAGES:0]          vld_q;
    logic signed [WA-1:0]     ar_q, ai_q;
    logic signed [WB-1:0]     br_q, bi_q;
    logic signed [MW-1:0]     p_rr_q, p_ii_q, p_ri_q, p_ir_q;
    logic signed [PW-1:0]     re_q [2:STAGES-1];
    logic signed [PW-1:0]     im_q [2:STAGES-1];
    logic [WO-1:0]            out_re_q, out_im_q;
    logic [WO-1:0]            re_sat_d, im_sat_d;

    function automatic logic [WO-1:0] scale(input logic signed [PW-1:0] x);
        logic signed [EW-1:0] xe;
        logic signed [EW-1:0] xs;
        xe = EW'(x);
        xs = xe >>> SH;
        if (xs > MAXV)      return MAXV[WO-1:0];
        else if (xs < MINV) return MINV[WO-1:0];
        else                return xs[WO-1:0];
    endfunction

    assign re_sat_d = scale(re_q[STAGES-1]);
    assign im_sat_d = scale(im_q[STAGES-1]);

    always_ff @(posedge aclk) begin
        if (areset) begin
            vld_q    <= '0;
            ar_q     <= '0;
            ai_q     <= '0;
            br_q     <= '0;
            bi_q     <= '0;
            p_rr_q   <= '0;
            p_ii_q   <= '0;
            p_ri_q   <= '0;
            p_ir_q   <= '0;
            for (int i = 2; i < STAGES; i++) begin
                re_q[i] <= '0;
                im_q[i] <= '0;
            end
            out_re_q <= '0;
            out_im_q <= '0;
        end else begin
            vld_q  <= {vld_q[STAGES-1:0], accept};
            ar_q   <= s_axis_a_tdata[WA-1:0];
            ai_q   <= s_axis_a_tdata[2*WA-1:WA];
            br_q   <= s_axis_b_tdata[WB-1:0];
            bi_q   <= s_axis_b_tdata[2*WB-1:WB];
            p_rr_q <= MW'(ar_q) * MW'(br_q);
            p_ii_q <= MW'(ai_q) * MW'(bi_q);
            p_ri_q <= MW'(ar_q) * MW'(bi_q);
            p_ir_q <= MW'(ai_q) * MW'(br_q);
            re_q[2] <= PW'(p_rr_q) - PW'(p_ii_q);
            im_q[2] <= PW'(p_ri_q) + PW'(p_ir_q);
            for (int i = 3; i < STAGES; i++) begin
                re_q[i] <= re_q[i-1];
                im_q[i] <= im_q[i-1];
            end
            // Output holds its last value between valid samples.
            if (vld_q[STAGES-1]) begin
                out_re_q <= re_sat_d;
                out_im_q <= im_sat_d;
            end
        end
    end

    assign m_axis_dout_tdata  = {out_im_q, out_re_q};
    assign m_axis_dout_tvalid = vld_q[STAGES];
endmodule

// File: tb/tb_complex_mult.sv
// Scoreboard bench for complex_mult: a non-blocking and a blocking instance share the
// stimulus; expected products come from a plain-integer reference model.
module tb_complex_mult;
    localparam int W  = 16;
    localparam int ST = 6;
    localparam int GB = -2;
    localparam int SH = W + W - W + 1 + GB;

    typedef struct {
        int          due;
        logic [31:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] a_d = '0;
    logic [31:0] b_d = '0;
    logic        a_v = 1'b0;
    logic        b_v = 1'b0;
    logic [31:0] d0, d1;
    logic        v0, v1;
    logic        done = 1'b0;

    exp_t        sbq [2][$];
    logic [31:0] hold [2];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    complex_mult #(
        .OPERAND_WIDTH_A(W), .OPERAND_WIDTH_B(W), .OPERAND_WIDTH_OUT(W),
        .STAGES(ST), .BLOCKING(0), .GROWTH_BITS(GB)
    ) dut0 (
        .aclk(clk), .areset(rst),
        .s_axis_a_tdata(a_d), .s_axis_a_tvalid(a_v),
        .s_axis_b_tdata(b_d), .s_axis_b_tvalid(b_v),
        .m_axis_dout_tdata(d0), .m_axis_dout_tvalid(v0)
    );

    complex_mult #(
        .OPERAND_WIDTH_A(W), .OPERAND_WIDTH_B(W), .OPERAND_WIDTH_OUT(W),
        .STAGES(ST), .BLOCKING(1), .GROWTH_BITS(GB)
    ) dut1 (
        .aclk(clk), .areset(rst),
        .s_axis_a_tdata(a_d), .s_axis_a_tvalid(a_v),
        .s_axis_b_tdata(b_d), .s_axis_b_tvalid(b_v),
        .m_axis_dout_tdata(d1), .m_axis_dout_tvalid(v1)
    );

    function automatic logic [15:0] sat16(input longint x);
        if (x > 32767)  return 16'h7fff;
        if (x < -32768) return 16'h8000;
        return x[15:0];
    endfunction

    // Complex product, floor division by 2^SH, then clamp each part.
    function automatic logic [31:0] ref_mult(input logic [31:0] a, input logic [31:0] b);
        longint ar, ai, br, bi, pre, pim;
        ar  = longint'($signed(a[15:0]));
        ai  = longint'($signed(a[31:16]));
        br  = longint'($signed(b[15:0]));
        bi  = longint'($signed(b[31:16]));
        pre = ar * br - ai * bi;
        pim = ar * bi + ai * br;
        return {sat16(pim >>> SH), sat16(pre >>> SH)};
    endfunction

    function automatic logic [31:0] pk(input int im, input int re);
        logic [15:0] i16, r16;
        i16 = im[15:0];
        r16 = re[15:0];
        return {i16, r16};
    endfunction

    function automatic logic [15:0] rcomp();
        case ($urandom_range(0, 7))
            0:       return 16'h8000;
            1:       return 16'h7fff;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic check(input int i, input logic v, input logic [31:0] d);
        logic ev;
        exp_t e;
        ev = (sbq[i].size() > 0) && (sbq[i][0].due == cyc);
        n_chk++;
        if (v !== ev) begin
            n_fail++;
            $display("FAIL valid[%0d] cyc %0d: got %b want %b", i, cyc, v, ev);
        end
        if (ev) begin
            e = sbq[i].pop_front();
            hold[i] = e.d;
        end
        n_chk++;
        if (d !== hold[i]) begin
            n_fail++;
            $display("FAIL data[%0d] cyc %0d: got %h want %h", i, cyc, d, hold[i]);
        end
    endtask

    // Scoreboard: model inputs at each edge, check outputs 1 time unit later.
    initial begin
        exp_t e;
        hold[0] = '0;
        hold[1] = '0;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                sbq[0].delete();
                sbq[1].delete();
                hold[0] = '0;
                hold[1] = '0;
            end else if (a_v) begin
                e.d   = ref_mult(a_d, b_d);
                e.due = cyc + ST;
                sbq[0].push_back(e);
                if (b_v) sbq[1].push_back(e);
            end
            #1;
            check(0, v0, d0);
            check(1, v1, d1);
            if (done) begin
                for (int i = 0; i < 2; i++) begin
                    n_chk++;
                    if (sbq[i].size() != 0) begin
                        n_fail++;
                        $display("FAIL drain[%0d]: %0d outputs missing, want 0", i, sbq[i].size());
                    end
                end
                $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
                $finish;
            end
        end
    end

    task automatic drive(input logic r, input logic av, input logic bv,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        rst = r;
        a_v = av;
        b_v = bv;
        a_d = a;
        b_d = b;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, a_d, b_d);
    endtask

    initial begin
        // Valid inputs during reset must not be accepted.
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b1, {rcomp(), rcomp()}, {rcomp(), rcomp()});
        drive(1'b0, 1'b1, 1'b1, pk(0, 1000), pk(0, 32767));
        idle(8);
        drive(1'b0, 1'b1, 1'b1, pk(1000, 0), pk(32767, 0));
        idle(8);
        drive(1'b0, 1'b1, 1'b1, pk(-32768, -32768), pk(32767, -32768));
        idle(8);
        // Lone a_tvalid: only the non-blocking instance accepts.
        drive(1'b0, 1'b1, 1'b0, pk(-5000, 12345), pk(20000, -7000));
        idle(8);
        drive(1'b0, 1'b1, 1'b1, pk(-5000, 12345), pk(20000, -7000));
        idle(8);
        for (int i = 0; i < 256; i++)
            drive(1'b0, 1'b1, 1'($urandom_range(0, 1)), {rcomp(), rcomp()}, {rcomp(), rcomp()});
        for (int i = 0; i < 64; i++)
            drive(1'b0, (i % 2) == 0, 1'b1, {rcomp(), rcomp()}, {rcomp(), rcomp()});
        for (int i = 0; i < 200; i++)
            drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  {rcomp(), rcomp()}, {rcomp(), rcomp()});
        idle(10);
        // Reset with four samples in flight, then one fresh sample.
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b1, {rcomp(), rcomp()}, {rcomp(), rcomp()});
        drive(1'b1, 1'b1, 1'b1, {rcomp(), rcomp()}, {rcomp(), rcomp()});
        drive(1'b0, 1'b1, 1'b1, pk(300, -2000), pk(-16384, 16384));
        idle(12);
        done = 1'b1;
    end
endmodule
